button_debounce: RTL and testbench

- Two-channel input conditioner between the raw board push-buttons and the button-to-LED decoder.
- Each channel synchronises its asynchronous pin to clk and filters contact bounce.
- Each channel outputs a clean, stable level (b1, b2) that drives the decoder directly, plus one-cycle press/release strobes for future sequential consumers.

---
 rtl/button_debounce.sv | 139 +++++++++++++
 tb/tb_button_debounce.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Two-channel push-button conditioner: 2-flop synchroniser, bounce filter and
// registered press/release strobes per channel. Outputs are 1 = pressed.
module button_debounce_chan #(
  parameter int unsigned STABLE_CYCLES = 120000,
  parameter int unsigned CNT_W         = 17,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             sync_n;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Polarity is fixed after the second flop so the synchroniser stays pure.
  assign sync_n = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= pin_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_n != level_q) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PENDING: begin
        if (sync_n == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_STABLE;
          cnt_d     = '0;
          level_d   = sync_n;
          press_d   = sync_n;
          release_d = ~sync_n;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 120000,
  parameter int unsigned CNT_W         = 17,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic b1_raw,
  input  logic b2_raw,
  output logic b1,
  output logic b2,
  output logic b1_press,
  output logic b2_press,
  output logic b1_release,
  output logic b2_release
);

  button_debounce_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_chan1 (
    .clk      (clk),
    .rst      (rst),
    .pin_i    (b1_raw),
    .level_o  (b1),
    .press_o  (b1_press),
    .release_o(b1_release)
  );

  button_debounce_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_chan2 (
    .clk      (clk),
    .rst      (rst),
    .pin_i    (b2_raw),
    .level_o  (b2),
    .press_o  (b2_press),
    .release_o(b2_release)
  );

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random pin activity on an
// active-high and an active-low instance, checked against a sample-window model.
module tb_button_debounce;

  localparam int S = 4;
  localparam logic [3:0] AL_MASK = 4'b1100;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] pin;
  logic [3:0] lvl, prs, rls;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model: a level flips when the last S synchronised samples (pins seen two
  // edges back and earlier) all disagree with it.
  logic [15:0] m_hist [4];
  logic [3:0]  m_lvl, m_prs, m_rls;

  button_debounce #(.STABLE_CYCLES(S), .CNT_W(17), .ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk(clk), .rst(rst), .b1_raw(pin[0]), .b2_raw(pin[1]),
    .b1(lvl[0]), .b2(lvl[1]), .b1_press(prs[0]), .b2_press(prs[1]),
    .b1_release(rls[0]), .b2_release(rls[1])
  );

  button_debounce #(.STABLE_CYCLES(S), .CNT_W(17), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .b1_raw(pin[2]), .b2_raw(pin[3]),
    .b1(lvl[2]), .b2(lvl[3]), .b1_press(prs[2]), .b2_press(prs[3]),
    .b1_release(rls[2]), .b2_release(rls[3])
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) m_hist[ch] = '0;
    m_lvl = '0;
    m_prs = '0;
    m_rls = '0;
  endtask

  task automatic model_step();
    logic all_new;
    for (int ch = 0; ch < 4; ch++) begin
      m_hist[ch] = {m_hist[ch][14:0], pin[ch] ^ AL_MASK[ch]};
      all_new = 1'b1;
      for (int k = 2; k <= S + 1; k++)
        if (m_hist[ch][k] == m_lvl[ch]) all_new = 1'b0;
      m_prs[ch] = all_new & ~m_lvl[ch];
      m_rls[ch] = all_new & m_lvl[ch];
      if (all_new) m_lvl[ch] = ~m_lvl[ch];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int ch = 0; ch < 4; ch++)
      check($sformatf("out ch%0d cyc%0d", ch, cyc),
            {29'd0, lvl[ch], prs[ch], rls[ch]},
            {29'd0, m_lvl[ch], m_prs[ch], m_rls[ch]});
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Edges counted from the first edge that samples the new pin value.
  task automatic wait_press(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!prs[ch] && n < 20);
  endtask

  task automatic pulse_reset(input int edges);
    #2 rst = 1'b1;
    #1 check("async_clear", {20'd0, lvl, prs, rls}, 32'd0);
    model_reset();
    repeat (edges) @(posedge clk);
    #4 rst = 1'b0;
  endtask

  initial begin
    int n, k0, rise_at, presses, releases, highs;
    int hold [4];

    clk_en = 1'b0;
    rst    = 1'b0;
    pin    = AL_MASK;

    // 1. Reset with the clock stopped
    #3 rst = 1'b1;
    #1 check("reset_state", {20'd0, lvl, prs, rls}, 32'd0);
    #2 rst = 1'b0;
    model_reset();
    clk_en = 1'b1;
    run_to(20);
    check("idle_after_reset", {20'd0, lvl, prs, rls}, 32'd0);

    // 2. Clean press and release, edge-exact
    cyc = 0;
    run_to(9);
    pin[0] = 1'b1;
    run_to(14);
    check("t2_before_edge15", {31'd0, lvl[0]}, 32'd0);
    tick();
    check("t2_press_edge15", {30'd0, lvl[0], prs[0]}, 32'd3);
    check("t2_ch2_quiet", {29'd0, lvl[1], prs[1], rls[1]}, 32'd0);
    tick();
    check("t2_press_edge16", {30'd0, lvl[0], prs[0]}, 32'd2);
    run_to(29);
    pin[0] = 1'b0;
    run_to(34);
    tick();
    check("t2_release_edge35", {30'd0, lvl[0], rls[0]}, 32'd1);
    tick();
    check("t2_release_edge36", {31'd0, rls[0]}, 32'd0);

    // 3. Bounce on b2: 1,0,1,1,0,1 then held high
    k0 = cyc + 1;
    rise_at = -1;
    presses = 0;
    releases = 0;
    for (int i = 0; i < 21; i++) begin
      pin[1] = (i < 6) ? ((i == 1 || i == 4) ? 1'b0 : 1'b1) : 1'b1;
      tick();
      if (prs[1]) presses++;
      if (rls[1]) releases++;
      if (lvl[1] && rise_at < 0) rise_at = cyc;
    end
    check("t3_rise_edge", rise_at - k0, 32'd10);
    check("t3_press_count", presses, 32'd1);
    check("t3_release_count", releases, 32'd0);

    pin[1] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rls[1] && n < 20);
    check("t3_release_wait", n, S + 2);
    repeat (2) tick();
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      pin[1] = (i < 3) ? 1'b1 : 1'b0;
      tick();
      if (lvl[1] || prs[1]) highs++;
    end
    check("t3_glitch_rejected", highs, 32'd0);

    // 4. Simultaneous press
    pin[1:0] = 2'b11;
    wait_press(0, n);
    check("t4_latency", n, S + 2);
    check("t4_both", {28'd0, lvl[1:0], prs[1:0]}, 32'hF);
    pin[1:0] = 2'b00;
    repeat (10) tick();

    // 5. Reset while a press is pending
    pin[0] = 1'b1;
    repeat (3) tick();
    pulse_reset(2);
    wait_press(0, n);
    check("t5_requalify", n, S + 2);
    presses = 0;
    repeat (10) begin
      tick();
      if (prs[0]) presses++;
    end
    check("t5_single_press", presses, 32'd0);
    pin[0] = 1'b0;
    repeat (10) tick();

    // 6. Active-low instance
    check("t6_al_idle", {28'd0, lvl[3:2], prs[3:2]}, 32'd0);
    pin[2] = 1'b0;
    wait_press(2, n);
    check("t6_al_latency", n, S + 2);
    check("t6_al_level", {31'd0, lvl[2]}, 32'd1);

    // Random pin activity, hold lengths spanning both sides of the filter
    for (int ch = 0; ch < 4; ch++) hold[ch] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          pin[ch] = ~pin[ch];
          hold[ch] = int'($urandom_range(1, 8));
        end
      end
      if (i == 1500) pulse_reset(int'($urandom_range(1, 3)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
